// File: rtl/status_pkg.sv
// Shared constants for the status/event register block: register map, response codes,
// default widths and small byte-lane helpers.
package status_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_NUM_EVENTS = 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [3:0] OFF_STATUS  = 4'h0;
  localparam logic [3:0] OFF_MASK    = 4'h4;
  localparam logic [3:0] OFF_EVCOUNT = 4'h8;
  localparam logic [3:0] OFF_SCRATCH = 4'hC;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_MASK    = 2'd1,
    REG_EVCOUNT = 2'd2,
    REG_SCRATCH = 2'd3
  } reg_sel_e;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/status_axil_if.sv
// AXI4-Lite slave handshake: turns bus transactions into single-cycle write/read strobes
// for the register core and holds the B/R responses until the master takes them.
module status_axil_if
  import status_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = DEF_DATA_W,
  parameter int C_S_AXI_ADDR_WIDTH = DEF_ADDR_W
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              wr_en,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     wr_data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   wr_strb,
  output logic                              rd_en,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     rd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     rd_data
);

  logic                          wr_ready;
  logic                          bvalid;
  logic                          rd_ready;
  logic                          rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

  // AW and W are taken together; the ready cycle is also the commit cycle, so the
  // master is still holding address/data while the core consumes them.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ready <= 1'b0;
      bvalid   <= 1'b0;
    end else begin
      wr_ready <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid && !wr_ready;
      if (wr_ready)
        bvalid <= 1'b1;
      else if (S_AXI_BREADY)
        bvalid <= 1'b0;
    end
  end

  // Read data is captured on the ARREADY edge, i.e. from register state before any
  // write committing on that same edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_ready <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      rd_ready <= S_AXI_ARVALID && !rvalid && !rd_ready;
      if (rd_ready) begin
        rvalid <= 1'b1;
        rdata  <= rd_data;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign wr_en   = wr_ready;
  assign wr_addr = S_AXI_AWADDR;
  assign wr_data = S_AXI_WDATA;
  assign wr_strb = S_AXI_WSTRB;
  assign rd_en   = rd_ready;
  assign rd_addr = S_AXI_ARADDR;

  assign S_AXI_AWREADY = wr_ready;
  assign S_AXI_WREADY  = wr_ready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = rd_ready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

endmodule

// File: rtl/status_event_regs.sv
// Sticky event status block: edge-detects evt_in into a W1C STATUS register, counts
// unmasked event cycles in EVCOUNT and raises irq for any unmasked sticky bit.
module status_event_regs
  import status_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = DEF_DATA_W,
  parameter int C_S_AXI_ADDR_WIDTH = DEF_ADDR_W,
  parameter int C_NUM_EVENTS       = DEF_NUM_EVENTS
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_NUM_EVENTS-1:0]           evt_in,
  output logic                              irq,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  logic                              wr_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wr_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wr_strb;
  logic                              rd_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     rd_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rd_data;

  status_axil_if #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
  ) u_axil_if (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  logic [C_NUM_EVENTS-1:0] status;
  logic [C_NUM_EVENTS-1:0] mask;
  logic [31:0]             evcount;
  logic [31:0]             scratch;
  logic [C_NUM_EVENTS-1:0] evt_hist;
  logic                    primed;

  reg_sel_e                wr_sel;
  reg_sel_e                rd_sel;
  logic [31:0]             byte_mask;
  logic [C_NUM_EVENTS-1:0] rise;
  logic [C_NUM_EVENTS-1:0] w1c;
  logic                    hit;
  logic                    cnt_clr;

  assign wr_sel    = reg_sel_e'(wr_addr[3:2]);
  assign rd_sel    = reg_sel_e'(rd_addr[3:2]);
  assign byte_mask = strb_to_mask(wr_strb);

  // No edges are reported until the history register has seen one real sample, so a
  // level held high across reset release is not mistaken for an event.
  assign rise    = primed ? (evt_in & ~evt_hist) : '0;
  assign hit     = |(rise & mask);
  assign w1c     = (wr_en && wr_sel == REG_STATUS) ?
                   (wr_data[C_NUM_EVENTS-1:0] & byte_mask[C_NUM_EVENTS-1:0]) : '0;
  assign cnt_clr = wr_en && (wr_sel == REG_EVCOUNT);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      evt_hist <= '0;
      primed   <= 1'b0;
      status   <= '0;
      irq      <= 1'b0;
    end else begin
      evt_hist <= evt_in;
      primed   <= 1'b1;
      status   <= (status & ~w1c) | rise;
      irq      <= |(status & mask);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mask    <= '0;
      scratch <= '0;
    end else if (wr_en) begin
      if (wr_sel == REG_MASK)
        mask <= (mask & ~byte_mask[C_NUM_EVENTS-1:0]) |
                (wr_data[C_NUM_EVENTS-1:0] & byte_mask[C_NUM_EVENTS-1:0]);
      if (wr_sel == REG_SCRATCH)
        scratch <= (scratch & ~byte_mask) | (wr_data & byte_mask);
    end
  end

  // A clear that lands on a counted cycle keeps that cycle's count.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      evcount <= '0;
    else if (cnt_clr)
      evcount <= {31'd0, hit};
    else if (hit)
      evcount <= sat_inc(evcount);
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (rd_sel)
        REG_STATUS:  rd_data = 32'(status);
        REG_MASK:    rd_data = 32'(mask);
        REG_EVCOUNT: rd_data = evcount;
        default:     rd_data = scratch;
      endcase
    end
  end

  logic unused_addr;
  assign unused_addr = ^{wr_addr[1:0], rd_addr[1:0]};

endmodule

// File: tb/tb_status_event_regs.sv
// Randomized and directed bench for status_event_regs with a cycle-level reference model
// of the register map and AXI4-Lite response rules.
module tb_status_event_regs;

  logic        ACLK;
  logic        ARESETN;
  logic [7:0]  evt_in;
  logic        irq;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  status_event_regs dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .evt_in        (evt_in),
    .irq           (irq),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  localparam logic [31:0] EVMASK = 32'h0000_00FF;
  localparam int          TMO    = 50;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  evt_drive = 8'h00;
  bit          rand_evt  = 1'b0;
  logic [31:0] rd;
  logic [31:0] rd_rand;

  // Reference state: register file indexed by address[3:2] plus bus-visible flags.
  logic [31:0] m_reg [4];
  logic        m_awready, m_bvalid, m_arready, m_rvalid, m_irq, m_primed;
  logic [31:0] m_rdata;
  logic [7:0]  m_hist;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] nreg [4];
    logic [31:0] bm;
    logic [7:0]  rise;
    longint      c;
    bit          cleared;
    logic        awr_n, bv_n, arr_n, rv_n;
    logic [31:0] rdat_n;
    if (!ARESETN) begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      m_awready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
      m_irq = 0; m_primed = 0; m_rdata = 32'h0; m_hist = 8'h00;
      return;
    end
    foreach (m_reg[i]) nreg[i] = m_reg[i];
    rise    = m_primed ? (evt_in & ~m_hist) : 8'h00;
    cleared = 0;
    bm      = 32'h0;
    if (m_awready) begin
      for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
      case (S_AXI_AWADDR[3:2])
        2'd0:    nreg[0] = m_reg[0] & ~(S_AXI_WDATA & bm);
        2'd1:    nreg[1] = ((m_reg[1] & ~bm) | (S_AXI_WDATA & bm)) & EVMASK;
        2'd2:    cleared = 1;
        default: nreg[3] = (m_reg[3] & ~bm) | (S_AXI_WDATA & bm);
      endcase
    end
    nreg[0] = nreg[0] | {24'h0, rise};
    c = cleared ? 64'd0 : {32'h0, m_reg[2]};
    if ((rise & m_reg[1][7:0]) != 8'h00) c = c + 1;
    if (c > 64'h0000_0000_FFFF_FFFF) c = 64'h0000_0000_FFFF_FFFF;
    nreg[2] = c[31:0];

    awr_n  = S_AXI_AWVALID && S_AXI_WVALID && !m_bvalid && !m_awready;
    bv_n   = m_awready || (m_bvalid && !S_AXI_BREADY);
    arr_n  = S_AXI_ARVALID && !m_rvalid && !m_arready;
    rv_n   = m_arready || (m_rvalid && !S_AXI_RREADY);
    rdat_n = m_arready ? m_reg[S_AXI_ARADDR[3:2]] : m_rdata;

    m_irq     = ((m_reg[0] & m_reg[1]) != 32'h0);
    m_awready = awr_n;
    m_bvalid  = bv_n;
    m_arready = arr_n;
    m_rvalid  = rv_n;
    m_rdata   = rdat_n;
    m_hist    = evt_in;
    m_primed  = 1'b1;
    foreach (m_reg[i]) m_reg[i] = nreg[i];
  endtask

  always @(posedge ACLK) begin
    model_step();
    #1;
    check1("awready", S_AXI_AWREADY, m_awready);
    check1("wready", S_AXI_WREADY, m_awready);
    check1("bvalid", S_AXI_BVALID, m_bvalid);
    check1("arready", S_AXI_ARREADY, m_arready);
    check1("rvalid", S_AXI_RVALID, m_rvalid);
    check32("rdata", S_AXI_RDATA, m_rdata);
    check32("resp", {28'h0, S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
    check1("irq", irq, m_irq);
  end

  always begin
    @(negedge ACLK);
    #1;
    evt_in = rand_evt ? 8'($urandom) : evt_drive;
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int bdelay, input logic [7:0] pulse);
    int t;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    t = 0;
    while (!S_AXI_AWREADY && t < TMO) begin @(negedge ACLK); t++; end
    if (pulse != 8'h00) evt_drive = pulse;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    if (pulse != 8'h00) evt_drive = 8'h00;
    while (!S_AXI_BVALID && t < TMO) begin @(negedge ACLK); t++; end
    check1("wr_timeout", t < TMO, 1'b1);
    repeat (bdelay) begin
      @(negedge ACLK);
      check1("bvalid_hold", S_AXI_BVALID, 1'b1);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, input int rdelay);
    int t;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!S_AXI_ARREADY && t < TMO) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    while (!S_AXI_RVALID && t < TMO) begin @(negedge ACLK); t++; end
    check1("rd_timeout", t < TMO, 1'b1);
    data = S_AXI_RDATA;
    repeat (rdelay) begin
      @(negedge ACLK);
      check1("rvalid_hold", S_AXI_RVALID, 1'b1);
      check32("rdata_hold", S_AXI_RDATA, data);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] scr_vals [4];
    int t;
    scr_vals[0] = 32'h0101_FFFF; scr_vals[1] = 32'hABCD_0001;
    scr_vals[2] = 32'hDEAD_0011; scr_vals[3] = 32'hBEEF_0011;
    ARESETN = 1'b0;
    S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'h0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'h0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check1("rst_awready", S_AXI_AWREADY, 1'b0);
    check1("rst_bvalid", S_AXI_BVALID, 1'b0);
    check1("rst_rvalid", S_AXI_RVALID, 1'b0);
    check32("rst_rdata", S_AXI_RDATA, 32'h0);
    check1("rst_irq", irq, 1'b0);

    foreach (scr_vals[i]) begin
      axi_write(4'hC, scr_vals[i], 4'hF, 0, 8'h00);
      axi_read(4'hC, rd, 0);
      check32("scratch_rb", rd, scr_vals[i]);
    end

    axi_write(4'h4, 32'h0000_0001, 4'hF, 0, 8'h00);
    @(negedge ACLK); evt_drive = 8'h01;
    @(negedge ACLK); evt_drive = 8'h00;
    check1("irq_one_cycle", irq, 1'b0);
    @(negedge ACLK);
    check1("irq_two_cycles", irq, 1'b1);
    axi_read(4'h0, rd, 0); check32("evt_status", rd, 32'h0000_0001);
    axi_read(4'h8, rd, 0); check32("evt_count", rd, 32'h0000_0001);
    axi_write(4'h0, 32'h0000_0001, 4'hF, 0, 8'h00);
    check1("irq_after_w1c", irq, 1'b0);
    axi_read(4'h0, rd, 0); check32("status_w1c", rd, 32'h0);

    axi_write(4'h0, 32'h0000_0008, 4'hF, 0, 8'h08);
    axi_read(4'h0, rd, 0); check32("set_wins", rd, 32'h0000_0008);

    axi_write(4'h4, 32'h0000_00FF, 4'hF, 0, 8'h00);
    axi_write(4'h8, 32'h0, 4'hF, 0, 8'h00);
    repeat (3) begin
      @(negedge ACLK); evt_drive = 8'h21;
      @(negedge ACLK); evt_drive = 8'h00;
    end
    @(negedge ACLK);
    axi_read(4'h8, rd, 0); check32("count_three", rd, 32'h0000_0003);
    axi_write(4'h8, 32'h0, 4'h0, 0, 8'h00);
    axi_read(4'h8, rd, 0); check32("count_clear", rd, 32'h0);

    // Backpressure: a second AW/W pair waits behind an unacknowledged B response.
    @(negedge ACLK);
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    t = 0;
    while (!S_AXI_AWREADY && t < TMO) begin @(negedge ACLK); t++; end
    check1("bp_first_accept", t < TMO, 1'b1);
    @(negedge ACLK);
    S_AXI_WDATA = 32'h5555_AAAA;
    repeat (5) begin
      check1("bp_bvalid_hold", S_AXI_BVALID, 1'b1);
      check1("bp_no_second", S_AXI_AWREADY, 1'b0);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check1("bp_not_yet", S_AXI_AWREADY, 1'b0);
    t = 0;
    while (!S_AXI_AWREADY && t < TMO) begin @(negedge ACLK); t++; end
    check1("bp_second_accept", t < TMO, 1'b1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    axi_read(4'hC, rd, 5); check32("bp_rdata", rd, 32'h5555_AAAA);

    rand_evt = 1'b1;
    for (int i = 0; i < 60; i++) begin
      fork
        axi_write({2'($urandom), 2'($urandom)}, $urandom, 4'($urandom),
                  int'($urandom_range(0, 3)), 8'h00);
        axi_read({2'($urandom), 2'($urandom)}, rd_rand, int'($urandom_range(0, 3)));
      join
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end
    rand_evt = 1'b0;
    repeat (2) @(negedge ACLK);

    // Reset in the middle of a pending write response, with events held high.
    evt_drive = 8'hFF;
    @(negedge ACLK);
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    t = 0;
    while (!S_AXI_AWREADY && t < TMO) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check1("rst_pre_bvalid", S_AXI_BVALID, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    check1("rst_async_bvalid", S_AXI_BVALID, 1'b0);
    check1("rst_async_irq", irq, 1'b0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      check1("rst_no_resp", S_AXI_BVALID, 1'b0);
    end
    axi_read(4'h0, rd, 0); check32("post_rst_status", rd, 32'h0);
    axi_read(4'h4, rd, 0); check32("post_rst_mask", rd, 32'h0);
    axi_read(4'h8, rd, 0); check32("post_rst_evcount", rd, 32'h0);
    axi_read(4'hC, rd, 0); check32("post_rst_scratch", rd, 32'h0);
    evt_drive = 8'h00;
    repeat (3) @(negedge ACLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/status_event_regs.md
STATUS_EVENT_REGS -- requirements
Module: status_event_regs

Interface
REQ-001 C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.
REQ-002 C_S_AXI_ADDR_WIDTH, 4, byte address width covering four 32-bit registers.
REQ-003 C_NUM_EVENTS, 8, number of event inputs (1..32).
REQ-004 ACLK  in  1  sole clock; all logic rising-edge.
REQ-005 ARESETN  in  1  asynchronous, active-low reset.
REQ-006 evt_in  in  C_NUM_EVENTS  event levels, synchronous to ACLK.
REQ-007 irq  out  1  registered interrupt, high while any unmasked sticky bit is set.
REQ-008 S_AXI_AWADDR/AWPROT/AWVALID  in  4/3/1; S_AXI_AWREADY  out  1  write address channel (AWPROT ignored).
REQ-009 S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1  write data channel.
REQ-010 S_AXI_BRESP/BVALID  out  2/1; S_AXI_BREADY  in  1  write response channel.
REQ-011 S_AXI_ARADDR/ARPROT/ARVALID  in  4/3/1; S_AXI_ARREADY  out  1  read address channel (ARPROT ignored).
REQ-012 S_AXI_RDATA/RRESP/RVALID  out  32/2/1; S_AXI_RREADY  in  1  read data channel.

Function
REQ-013 Register map, decoded on address bits [3:2]: 0x0 STATUS (sticky, W1C), 0x4 MASK (RW), 0x8 EVCOUNT (RO; any write clears it), 0xC SCRATCH (RW).
REQ-014 The write path SHALL accept a write only when AWVALID and WVALID are both high, BVALID is low, and the ready outputs are low; it then pulses AWREADY and WREADY high together for exactly one cycle.
REQ-015 The register update SHALL take effect on the same edge that deasserts the ready outputs; BVALID SHALL rise on that edge and hold until BREADY is sampled high.
REQ-016 While BVALID is high, no new write SHALL be accepted.
REQ-017 Write strobes SHALL gate each byte of MASK, SCRATCH and the STATUS W1C mask; for EVCOUNT, any strobe pattern clears it.
REQ-018 The read path SHALL pulse ARREADY for one cycle when ARVALID is high, RVALID is low and ARREADY is low.
REQ-019 RDATA SHALL be registered on the ARREADY edge and RVALID asserted on that same edge; both hold stable until RREADY is sampled high.
REQ-020 BRESP and RRESP SHALL always be 2'b00 (OKAY); unimplemented upper bits of STATUS and MASK read as 0.
REQ-021 evt_in SHALL be registered once; a rising edge (prev 0, now 1) on bit i sets STATUS[i] on the next edge.
REQ-022 A simultaneous event set and W1C on the same bit SHALL leave the bit set (set wins).
REQ-023 EVCOUNT SHALL increment by 1 per cycle in which any rising edge occurs on an unmasked event, regardless of how many bits rise in that cycle.
REQ-024 EVCOUNT SHALL saturate at 0xFFFFFFFF.
REQ-025 A clear of EVCOUNT coinciding with a counted edge SHALL load EVCOUNT with 1.
REQ-026 irq SHALL equal the registered value of |(STATUS & MASK), i.e. one cycle after STATUS or MASK changes.
REQ-027 Read and write paths SHALL be independent and may complete in the same cycle.
REQ-028 A read of STATUS issued in the same cycle a W1C takes effect SHALL return the pre-write value.

Reset
REQ-029 On ARESETN low, asynchronously: all READY/VALID outputs 0, RDATA 0, STATUS 0, MASK 0, EVCOUNT 0, SCRATCH 0, irq 0, event history register 0.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction; no response is produced after release.
REQ-031 evt_in held high through reset release SHALL NOT generate an edge, because the event history register is loaded from evt_in on the first post-reset edge without setting STATUS.

Structure
REQ-032 Register offsets, RESP_OKAY and default widths SHALL live in the shared package status_pkg.
REQ-033 The AXI4-Lite handshake logic SHALL be one sub-module, status_axil_if, exposing a single-cycle wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data strobe interface to the register core.

Verification
REQ-034 SCRATCH test: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0xC, each read back -> identical data, RESP=OKAY.
REQ-035 Event test: MASK=0x01, pulse evt_in[0] for 1 cycle -> STATUS=0x01, EVCOUNT=1, irq=1 two cycles after the pulse; write 0x01 to 0x0 -> STATUS=0, irq=0.
REQ-036 Set-wins test: pulse evt_in[3] so that it coincides with a W1C of bit 3 -> STATUS[3]=1 on readback.
REQ-037 Count test: MASK=0xFF, three pulses with evt_in[0] and evt_in[5] rising together -> EVCOUNT=3; write 0 to 0x8 -> EVCOUNT=0.
REQ-038 Backpressure test: hold BREADY and RREADY low for 5 cycles -> BVALID/RVALID and RDATA stable, and a second AW/W pair is not accepted until BREADY goes high.
REQ-039 Reset test: assert ARESETN low while BVALID=1 -> BVALID=0 immediately; after release, all registers read 0.
